// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter: frame-atomic round-robin merge of NUM_PORTS AXI-Stream requesters with stall abort.
// ETH_TX_ARB_STRICT_PRIO_EN selects fixed lowest-index-first priority instead of round-robin.
module eth_tx_frame_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    s_tvalid,
  output logic [NUM_PORTS-1:0]    s_tready,
  input  logic [32*NUM_PORTS-1:0] s_tdata,
  input  logic [4*NUM_PORTS-1:0]  s_tkeep,
  input  logic [NUM_PORTS-1:0]    s_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [31:0]             m_tdata,
  output logic [3:0]              m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tuser,
  output logic [NUM_PORTS-1:0]    grant,
  output logic [15:0]             frame_count,
  output logic [15:0]             abort_count
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int SW = STALL_TIMEOUT > 1 ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [SW-1:0] LIM = SW'(STALL_TIMEOUT > 0 ? STALL_TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, ACTIVE, ABORT, DISCARD} state_t;
  state_t               state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [IW-1:0]        gidx_q, win;
  logic [SW-1:0]        stall_q;
  logic [15:0]          frame_q, abort_q;
  logic                 gv, gl;
  assign gv          = s_tvalid[gidx_q];
  assign gl          = s_tlast[gidx_q];
  assign grant       = grant_q;
  assign frame_count = frame_q;
  assign abort_count = abort_q;
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) if (s_tvalid[IW'(i)]) win = IW'(i);
  end
`else
  logic [IW-1:0] last_q;
  // Walk offsets from farthest to nearest so the nearest valid port after last_q wins.
  always_comb begin
    int t;
    win = last_q;
    t   = 0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      t = int'(last_q) + k;
      if (t >= NUM_PORTS) t -= NUM_PORTS;
      if (s_tvalid[IW'(t)]) win = IW'(t);
    end
  end
`endif
  always_comb begin
    m_tvalid = state_q == ACTIVE ? gv : state_q == ABORT;
    m_tlast  = state_q == ACTIVE ? gl : state_q == ABORT;
    m_tuser  = state_q == ABORT;
    m_tdata  = state_q == ACTIVE ? s_tdata[32*gidx_q +: 32] : '0;
    m_tkeep  = state_q == ACTIVE ? s_tkeep[4*gidx_q +: 4] : '0;
    s_tready = state_q == ACTIVE ? grant_q & {NUM_PORTS{m_tready}} : state_q == DISCARD ? grant_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      stall_q <= '0;
      frame_q <= '0;
      abort_q <= '0;
`ifndef ETH_TX_ARB_STRICT_PRIO_EN
      last_q  <= IW'(NUM_PORTS - 1);
`endif
    end else begin
      case (state_q)
        IDLE: if (|s_tvalid) begin
          state_q <= ACTIVE;
          gidx_q  <= win;
          grant_q <= NUM_PORTS'(1) << win;
          stall_q <= '0;
`ifndef ETH_TX_ARB_STRICT_PRIO_EN
          last_q  <= win;
`endif
        end
        ACTIVE: if (gv && m_tready && gl) begin
          state_q <= IDLE;
          grant_q <= '0;
          stall_q <= '0;
          frame_q <= frame_q + 16'd1;
        end else if (gv) begin
          stall_q <= '0;
        end else if (STALL_TIMEOUT != 0) begin
          if (stall_q == LIM) begin
            state_q <= ABORT;
            stall_q <= '0;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
        end
        ABORT: if (m_tready) begin
          state_q <= DISCARD;
          abort_q <= abort_q + 16'd1;
        end
        DISCARD: if (gv && gl) begin
          state_q <= IDLE;
          grant_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb_eth_tx_frame_arbiter: directed and randomized checks of eth_tx_frame_arbiter against a frame-level model.
module tb_eth_tx_frame_arbiter;
  logic         clk, rst;
  logic [3:0]   s_tvalid, s_tready, s_tlast, grant;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         m_tvalid, m_tready, m_tlast, m_tuser;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic [15:0]  frame_count, abort_count;
  int           checks, errors, mlast, e, len, nfr, cyc;
  int           bub[4];
  logic [15:0]  fc0, ab0;
  logic [3:0]   hs, mk;
  logic [36:0]  bt;
  logic [36:0]  dq[4][$];
  logic [36:0]  mq[4][$];
  logic [36:0]  exq[$];

  eth_tx_frame_arbiter #(.NUM_PORTS(4), .STALL_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .grant(grant), .frame_count(frame_count), .abort_count(abort_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic clr();
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    m_tready = 1'b1;
  endtask

  task automatic set_beat(input int p, input logic [31:0] d, input logic [3:0] k, input logic l);
    s_tvalid[p]        = 1'b1;
    s_tdata[32*p +: 32] = d;
    s_tkeep[4*p +: 4]  = k;
    s_tlast[p]         = l;
  endtask

  // Arbitration rule: next owner among the requesting set given the previous owner.
  function automatic int next_port(input int last, input logic [3:0] m);
    if (last < 0) return -1;
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
    for (int i = 0; i < 4; i++) if (m[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (m[(last + k) % 4]) return (last + k) % 4;
`endif
    return -1;
  endfunction

  task automatic rr_run(input logic [3:0] mask, input int n, input string tag);
    logic [15:0] f0;
    clr();
    for (int p = 0; p < 4; p++) if (mask[p]) set_beat(p, 32'hC0DE_0000 | 32'(p), 4'hF, 1'b1);
    f0 = frame_count;
    for (int f = 0; f < n; f++) begin
      tick();
      e = next_port(mlast, mask);
      chk({tag, "_grant"}, 64'(grant), 64'(1) << e);
      mlast = e;
      neg();
      chk({tag, "_data"}, {m_tvalid, m_tlast, m_tdata}, {2'b11, 32'hC0DE_0000 | 32'(e)});
      tick();
    end
    s_tvalid = '0;
    chk({tag, "_frames"}, frame_count, 16'(f0 + n));
  endtask

  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      s_tvalid[p] = dq[p].size() > 0 && bub[p] == 0;
      if (dq[p].size() > 0) begin
        bt = dq[p][0];
        s_tdata[32*p +: 32] = bt[31:0];
        s_tkeep[4*p +: 4]  = bt[35:32];
        s_tlast[p]         = bt[36];
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mlast  = 3;
    rst    = 1'b1;
    clr();
    repeat (3) tick();
    rst = 1'b0;
    neg();
    chk("reset_outs", {grant, s_tready, m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata}, '0);
    chk("reset_cnts", {frame_count, abort_count}, '0);
    rr_run(4'b1111, 5, "all_1beat");
    rr_run(4'b1001, 6, "ports_0_3");
    // Randomized frames with random backpressure and short mid-frame bubbles.
    nfr = 0;
    for (int p = 0; p < 4; p++) begin
      bub[p] = 0;
      repeat ($urandom_range(4, 1)) begin
        len = $urandom_range(5, 1);
        for (int b = 0; b < len; b++) begin
          bt = {1'(b == len - 1), 4'($urandom), $urandom};
          dq[p].push_back(bt);
          mq[p].push_back(bt);
        end
      end
    end
    while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() > 0) begin
      for (int p = 0; p < 4; p++) mk[p] = mq[p].size() > 0;
      e = next_port(mlast, mk);
      do begin
        bt = mq[e].pop_front();
        exq.push_back(bt);
      end while (!bt[36]);
      mlast = e;
      nfr++;
    end
    fc0 = frame_count;
    ab0 = abort_count;
    clr();
    drive();
    cyc = 0;
    while (exq.size() > 0 && cyc < 4000) begin
      neg();
      hs = s_tvalid & s_tready;
      if (m_tvalid && m_tready) begin
        bt = exq.pop_front();
        chk("rand_beat", {m_tuser, m_tlast, m_tkeep, m_tdata}, {1'b0, bt});
      end
      tick();
      for (int p = 0; p < 4; p++) begin
        if (hs[p]) begin
          bt = dq[p].pop_front();
          if (!bt[36] && $urandom_range(3, 0) == 0) bub[p] = $urandom_range(3, 1);
        end else if (bub[p] > 0) begin
          bub[p]--;
        end
      end
      drive();
      m_tready = $urandom_range(3, 0) != 0;
      cyc++;
    end
    chk("rand_drained", 64'(exq.size()), 0);
    chk("rand_frames", frame_count, 16'(fc0 + nfr));
    chk("rand_aborts", abort_count, ab0);
    // Three-beat frame on port 2 with long backpressure on beat 2.
    clr();
    fc0 = frame_count;
    ab0 = abort_count;
    set_beat(2, 32'h2000_0001, 4'hF, 1'b0);
    tick();
    chk("bp_grant", 64'(grant), 64'b0100);
    mlast = 2;
    neg();
    chk("bp_beat1", {m_tvalid, m_tlast, s_tready, m_tdata}, {2'b10, 4'b0100, 32'h2000_0001});
    tick();
    set_beat(2, 32'h2000_0002, 4'h3, 1'b0);
    m_tready = 1'b0;
    repeat (12) begin
      neg();
      chk("bp_hold", {m_tvalid, m_tuser, s_tready, m_tkeep, m_tdata}, {2'b10, 4'b0000, 4'h3, 32'h2000_0002});
      tick();
    end
    m_tready = 1'b1;
    neg();
    chk("bp_beat2", {m_tvalid, s_tready, m_tdata}, {1'b1, 4'b0100, 32'h2000_0002});
    tick();
    set_beat(2, 32'h2000_0003, 4'h1, 1'b1);
    neg();
    chk("bp_beat3", {m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata}, {3'b110, 4'h1, 32'h2000_0003});
    tick();
    s_tvalid = '0;
    chk("bp_done", {grant, frame_count, abort_count}, {4'b0000, 16'(fc0 + 1), ab0});
    // Port 1 goes silent after one beat: abort beat then discard the rest.
    clr();
    fc0 = frame_count;
    set_beat(1, 32'h1111_0001, 4'hF, 1'b0);
    tick();
    chk("to_grant", 64'(grant), 64'b0010);
    mlast = 1;
    tick();
    s_tvalid = '0;
    repeat (8) begin
      neg();
      chk("to_quiet", {m_tvalid, m_tuser}, 2'b00);
      tick();
    end
    m_tready = 1'b0;
    repeat (2) begin
      neg();
      chk("to_abort_hold", {m_tvalid, m_tlast, m_tuser, s_tready, m_tkeep, m_tdata}, {3'b111, 40'h0});
      chk("to_abcnt_hold", abort_count, ab0);
      tick();
    end
    m_tready = 1'b1;
    neg();
    chk("to_abort", {m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata}, {3'b111, 36'h0});
    tick();
    chk("to_abcnt", abort_count, 16'(ab0 + 1));
    set_beat(1, 32'hDEAD_0002, 4'hF, 1'b0);
    m_tready = 1'b0;
    neg();
    chk("to_discard1", {m_tvalid, s_tready}, {1'b0, 4'b0010});
    tick();
    set_beat(1, 32'hDEAD_0003, 4'hF, 1'b1);
    neg();
    chk("to_discard2", {m_tvalid, s_tready}, {1'b0, 4'b0010});
    tick();
    s_tvalid = '0;
    chk("to_done", {grant, frame_count, abort_count}, {4'b0000, fc0, 16'(ab0 + 1)});
    // Port 0 tlast arrives on the cycle the stall counter would expire.
    clr();
    fc0 = frame_count;
    ab0 = abort_count;
    set_beat(0, 32'h0000_0A01, 4'hF, 1'b0);
    tick();
    chk("edge_grant", 64'(grant), 64'b0001);
    mlast = 0;
    tick();
    s_tvalid = '0;
    repeat (7) tick();
    set_beat(0, 32'h0000_0A02, 4'h7, 1'b1);
    neg();
    chk("edge_last", {m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata}, {3'b110, 4'h7, 32'h0000_0A02});
    tick();
    s_tvalid = '0;
    chk("edge_done", {grant, frame_count, abort_count}, {4'b0000, 16'(fc0 + 1), ab0});
    // Reset in the middle of a port-1 frame.
    clr();
    set_beat(1, 32'h1010_0001, 4'hF, 1'b0);
    tick();
    chk("rst_pre_grant", 64'(grant), 64'b0010);
    tick();
    rst = 1'b1;
    for (int p = 0; p < 4; p++) set_beat(p, 32'hC0DE_0000 | 32'(p), 4'hF, 1'b1);
    tick();
    chk("rst_grant", 64'(grant), 0);
    neg();
    chk("rst_outs", {m_tvalid, m_tlast, m_tuser, s_tready, frame_count, abort_count}, '0);
    rst = 1'b0;
    tick();
    chk("rst_first_grant", 64'(grant), 64'b0001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_tx_frame_arbiter.md
ETH_TX_FRAME_ARBITER -- requirements
Module: eth_tx_frame_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4 (2..8): number of frame requesters.
REQ-002 SHALL have parameter STALL_TIMEOUT, default 1024: mid-frame idle cycles tolerated before abort; 0 disables abort.
REQ-003 SHALL have clk  input  1  single clock for all logic; one clock, reset is synchronous and active-high.
REQ-004 SHALL have rst  input  1  synchronous active-high reset.
REQ-005 SHALL have s_tvalid  input  NUM_PORTS  per-requester beat valid.
REQ-006 SHALL have s_tready  output  NUM_PORTS  per-requester beat accept.
REQ-007 SHALL have s_tdata  input  32*NUM_PORTS  per-requester data, port i at bits [32i+31:32i].
REQ-008 SHALL have s_tkeep  input  4*NUM_PORTS  per-requester byte keep, port i at [4i+3:4i].
REQ-009 SHALL have s_tlast  input  NUM_PORTS  per-requester end of frame.
REQ-010 SHALL have m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast  output/input/output/output/output  1/1/32/4/1  merged stream to MAC.
REQ-011 SHALL have m_tuser  output  1  asserted with m_tlast on an aborted frame (MAC drops frame).
REQ-012 SHALL have grant  output  NUM_PORTS  one-hot current owner, zero when idle.
REQ-013 SHALL have frame_count / abort_count  output  16 each  completed / aborted frames, wrap modulo 2^16.

Function
REQ-014 SHALL implement states IDLE, ACTIVE, ABORT, DISCARD.
REQ-015 IDLE: when any s_tvalid high, SHALL select winner, register grant, enter ACTIVE next cycle; all s_tready and m_tvalid low in IDLE.
REQ-016 Round-robin: search SHALL begin at (last_grant+1) mod NUM_PORTS; last_grant updates on each grant.
REQ-017 ACTIVE: m_* SHALL combinationally mirror granted port; s_tready[g]=m_tready; all other s_tready low; m_tuser low.
REQ-018 Beat acceptance SHALL be m_tvalid&&m_tready; on accepted tlast SHALL return to IDLE next cycle, increment frame_count, clear grant.
REQ-019 Frame switching SHALL occur only at frame boundaries; new frame start requires one IDLE cycle (1-cycle arbitration latency).
REQ-020 Stall counter SHALL count consecutive ACTIVE cycles with s_tvalid[g] low, clear on any granted valid; backpressure (m_tready low) SHALL NOT count.
REQ-021 Counter reaching STALL_TIMEOUT SHALL enter ABORT: m_tvalid=1, m_tlast=1, m_tuser=1, m_tkeep=0, m_tdata=0 held until m_tready; then DISCARD, increment abort_count.
REQ-022 DISCARD: s_tready[g]=1, m_tvalid=0, beats dropped until granted tlast accepted, then IDLE.
REQ-023 tlast arriving on the same cycle as timeout SHALL win: frame completes normally, no abort.
REQ-024 Requester deasserting s_tvalid while in IDLE before grant SHALL NOT be granted (selection uses same-cycle valids).
REQ-025 frame_count and abort_count SHALL wrap 0xFFFF->0x0000 without saturation.

Reset
REQ-026 On rst SHALL enter IDLE; grant=0, s_tready=0, m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, m_tkeep=0, counters=0, stall counter=0.
REQ-027 last_grant SHALL reset to NUM_PORTS-1 so port 0 wins first.
REQ-028 rst mid-frame SHALL abandon frame without emitting tlast; downstream reset is system responsibility.

Configuration
REQ-029 Macro ETH_TX_ARB_STRICT_PRIO_EN defined: IDLE selection SHALL always pick lowest-index valid port; last_grant unused.
REQ-030 Macro undefined: round-robin per REQ-016.

Verification
REQ-031 All ports valid, 1-beat frames, m_tready=1 -> grant order 0,1,2,3,0; frame_count=5 after 10 cycles.
REQ-032 Port 2 sends 3-beat frame, m_tready low on beat 2 for 4 cycles -> 3 beats in order, tlast on beat 3, no abort, stall counter 0.
REQ-033 STALL_TIMEOUT=8, port 1 stops after beat 1 -> after 8 idle cycles single beat tlast=1 tuser=1 tkeep=0; later port-1 beats dropped until tlast; abort_count=1.
REQ-034 Port 0 tlast coincides with timeout cycle -> normal completion, frame_count+1, abort_count unchanged.
REQ-035 ETH_TX_ARB_STRICT_PRIO_EN defined, ports 0 and 3 continuously valid -> port 3 never granted.
REQ-036 rst asserted mid-frame on port 1 -> next cycle grant=0, m_tvalid=0; first post-reset grant goes to port 0.
